// File: rtl/scnn_pkg.sv
// rtl/scnn_pkg.sv - shared constants, group type and FSM state for the SCNN compressed format
package scnn_pkg;

   localparam int LANES  = 4;
   localparam int DATA_W = 8;
   localparam int IDX_W  = 8;
   // lane counter must hold 0..LANES inclusive
   localparam int LCNT_W = $clog2(LANES + 1);

   // one compressed group: lane 0 occupies the least significant slice of data/cidx/mask
   typedef struct packed {
      logic [LANES-1:0][DATA_W-1:0] data;
      logic [LANES-1:0][IDX_W-1:0]  cidx;
      logic [IDX_W-1:0]             offset;
      logic [LANES-1:0]             mask;
      logic                         last;
   } scnn_grp_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } scnn_state_e;

endpackage

// File: rtl/scnn_grp_reg.sv
// rtl/scnn_grp_reg.sv - one-entry valid/ready output register holding a compressed group
module scnn_grp_reg
   import scnn_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      load,
   input  scnn_grp_t grp_in,
   input  logic      out_ready,
   output logic      out_valid,
   output scnn_grp_t grp_out
);

   logic      valid_q, valid_d;
   scnn_grp_t grp_q, grp_d;

   // a load always wins; the producer only loads when the slot is free or being drained
   always_comb begin
      valid_d = valid_q;
      grp_d   = grp_q;
      if (load) begin
         valid_d = 1'b1;
         grp_d   = grp_in;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // hold fields stable until the consumer takes the group
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         grp_q   <= '0;
      end else begin
         valid_q <= valid_d;
         grp_q   <= grp_d;
      end
   end

   assign out_valid = valid_q;
   assign grp_out   = grp_q;

endmodule

// File: rtl/scnn_sparse_encoder.sv
// rtl/scnn_sparse_encoder.sv - dense plane to SCNN compressed groups of nonzeros with zero-run indices
module scnn_sparse_encoder
   import scnn_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [IDX_W-1:0]        plane_size,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [LANES*IDX_W-1:0]  out_cidx,
   output logic [IDX_W-1:0]        out_offset,
   output logic [LANES-1:0]        out_mask,
   output logic                    out_last
);

   scnn_state_e                  state_q, state_d;
   logic [IDX_W-1:0]             elem_cnt_q, elem_cnt_d;
   logic [IDX_W-1:0]             psize_q, psize_d;
   logic [IDX_W-1:0]             zero_run_q, zero_run_d;
   logic [IDX_W-1:0]             next_off_q, next_off_d;
   logic [IDX_W-1:0]             grp_off_q, grp_off_d;
   logic [LCNT_W-1:0]            lane_cnt_q, lane_cnt_d;
   logic [LANES-1:0][DATA_W-1:0] lane_data_q, lane_data_d;
   logic [LANES-1:0][IDX_W-1:0]  lane_cidx_q, lane_cidx_d;

   logic                         accept;
   logic                         in_plane;
   logic                         is_last;
   logic                         is_nz;
   logic                         emit;
   logic [IDX_W-1:0]             cur_idx;
   logic [IDX_W-1:0]             cur_psize;
   logic [IDX_W-1:0]             cur_zr;
   logic [IDX_W-1:0]             cur_off;
   logic [IDX_W-1:0]             cur_goff;
   logic [LCNT_W-1:0]            cur_lane;
   logic [LANES-1:0][DATA_W-1:0] cur_data;
   logic [LANES-1:0][IDX_W-1:0]  cur_cidx;

   scnn_grp_t                    grp_new;
   scnn_grp_t                    grp_q;
   logic                         grp_load;

   // zeros are stalled too: nothing is accepted while a group is blocked in the output slot
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign in_plane = (state_q == ST_COLLECT);
   assign is_nz    = |in_data;

   // first beat of a plane sees a fresh context regardless of leftover register contents
   always_comb begin
      cur_idx   = in_plane ? elem_cnt_q  : '0;
      cur_psize = in_plane ? psize_q     : plane_size;
      cur_zr    = in_plane ? zero_run_q  : '0;
      cur_off   = in_plane ? next_off_q  : '0;
      cur_goff  = in_plane ? grp_off_q   : '0;
      cur_lane  = in_plane ? lane_cnt_q  : '0;
      cur_data  = in_plane ? lane_data_q : '0;
      cur_cidx  = in_plane ? lane_cidx_q : '0;
      is_last   = (cur_idx == (cur_psize - IDX_W'(1)));
   end

   // per-beat update of run/offset/lane bookkeeping and group formation
   always_comb begin
      state_d     = state_q;
      elem_cnt_d  = elem_cnt_q;
      psize_d     = psize_q;
      zero_run_d  = zero_run_q;
      next_off_d  = next_off_q;
      grp_off_d   = grp_off_q;
      lane_cnt_d  = lane_cnt_q;
      lane_data_d = lane_data_q;
      lane_cidx_d = lane_cidx_q;
      grp_new     = '0;
      grp_load    = 1'b0;
      emit        = 1'b0;
      if (accept) begin
         lane_data_d = cur_data;
         lane_cidx_d = cur_cidx;
         lane_cnt_d  = cur_lane;
         grp_off_d   = cur_goff;
         next_off_d  = cur_off;
         if (is_nz) begin
            for (int k = 0; k < LANES; k++) begin
               if (cur_lane == LCNT_W'(k)) begin
                  lane_data_d[k] = in_data;
                  lane_cidx_d[k] = cur_zr;
               end
            end
            if (cur_lane == '0) begin
               grp_off_d = cur_off;
            end
            zero_run_d = '0;
            next_off_d = cur_idx + IDX_W'(1);
            lane_cnt_d = cur_lane + LCNT_W'(1);
         end else begin
            zero_run_d = cur_zr + IDX_W'(1);
         end

         emit = (lane_cnt_d == LCNT_W'(LANES)) || is_last;
         if (emit) begin
            grp_load       = 1'b1;
            grp_new.data   = lane_data_d;
            grp_new.cidx   = lane_cidx_d;
            // an empty group reports where the next nonzero would have started
            grp_new.offset = (lane_cnt_d == '0) ? next_off_d : grp_off_d;
            for (int k = 0; k < LANES; k++) begin
               grp_new.mask[k] = (LCNT_W'(k) < lane_cnt_d);
            end
            grp_new.last   = is_last;
            lane_cnt_d     = '0;
            lane_data_d    = '0;
            lane_cidx_d    = '0;
         end

         if (is_last) begin
            state_d    = ST_IDLE;
            elem_cnt_d = '0;
            psize_d    = '0;
            zero_run_d = '0;
            next_off_d = '0;
            grp_off_d  = '0;
         end else begin
            state_d    = ST_COLLECT;
            elem_cnt_d = cur_idx + IDX_W'(1);
            psize_d    = cur_psize;
         end
      end
   end

   // plane state, counters and lane buffers; reset discards any partial plane
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         elem_cnt_q  <= '0;
         psize_q     <= '0;
         zero_run_q  <= '0;
         next_off_q  <= '0;
         grp_off_q   <= '0;
         lane_cnt_q  <= '0;
         lane_data_q <= '0;
         lane_cidx_q <= '0;
      end else begin
         state_q     <= state_d;
         elem_cnt_q  <= elem_cnt_d;
         psize_q     <= psize_d;
         zero_run_q  <= zero_run_d;
         next_off_q  <= next_off_d;
         grp_off_q   <= grp_off_d;
         lane_cnt_q  <= lane_cnt_d;
         lane_data_q <= lane_data_d;
         lane_cidx_q <= lane_cidx_d;
      end
   end

   // a plane of zero elements has no defined encoding
   a_plane_size_nonzero : assert property (
      @(posedge clk) disable iff (!rst_n) (accept && !in_plane) |-> (plane_size != '0)
   );

   scnn_grp_reg u_grp_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (grp_load),
      .grp_in    (grp_new),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .grp_out   (grp_q)
   );

   assign out_data   = grp_q.data;
   assign out_cidx   = grp_q.cidx;
   assign out_offset = grp_q.offset;
   assign out_mask   = grp_q.mask;
   assign out_last   = grp_q.last;

endmodule
